// File: rtl/inst_ram_loader_if.sv
// Program-stream handshake and instruction-RAM write port between the boot
// loader (slave) and the program source / CPU RAM side (master).
interface inst_ram_loader_if;
    logic        src_valid;
    logic [31:0] src_data;
    logic        src_last;
    logic        src_ready;
    logic        inst_ram_write_enable;
    logic [31:0] inst_ram_write_data;
    logic [31:0] inst_ram_write_address;

    modport master (
        output src_valid,
        output src_data,
        output src_last,
        input  src_ready,
        input  inst_ram_write_enable,
        input  inst_ram_write_data,
        input  inst_ram_write_address
    );

    modport slave (
        input  src_valid,
        input  src_data,
        input  src_last,
        output src_ready,
        output inst_ram_write_enable,
        output inst_ram_write_data,
        output inst_ram_write_address
    );
endinterface

// File: rtl/inst_ram_loader.sv
// Boot-time loader: streams instruction words into the CPU instruction RAM,
// holds the CPU in reset/debug while loading, then releases it after a settle
// period. Optional program checksum check: define INST_LOADER_CHECKSUM_EN.
module inst_ram_loader #(
    parameter logic [31:0] PC_INITIAL    = 32'hbfc00000,
    parameter int          MAX_WORDS     = 1024,
    parameter int          SETTLE_CYCLES = 8,
    localparam int         CNT_W         = $clog2(MAX_WORDS + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    inst_ram_loader_if.slave     bus,
    input  logic [31:0]          expected_checksum,
    output logic                 cpu_reset,
    output logic                 debug,
    output logic                 done,
    output logic                 error,
    output logic [CNT_W-1:0]     word_count
);

    localparam int ST_W = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_RUN,
        ST_ERROR
    } state_t;

    state_t            state_reg, state_next;
    logic [31:0]       next_addr_reg, next_addr_next;
    logic [CNT_W-1:0]  word_count_reg, word_count_next;
    logic [ST_W-1:0]   settle_reg, settle_next;
    logic              we_reg, we_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic [31:0]       waddr_reg, waddr_next;
    logic              cpu_reset_reg;
    logic              debug_reg;
    logic              done_reg;
    logic              error_reg;
    logic              src_ready_reg;
    logic              beat;
    logic              checksum_ok;

`ifdef INST_LOADER_CHECKSUM_EN
    logic [31:0]       sum_reg, sum_next;
    logic [31:0]       sum_with_beat;

    assign sum_with_beat = sum_reg + bus.src_data;
    // The final word is included in the comparison, hence sum_with_beat.
    assign checksum_ok   = (sum_with_beat == expected_checksum);
`else
    logic              unused_checksum;

    assign unused_checksum = ^expected_checksum;
    assign checksum_ok     = 1'b1;
`endif

    assign beat = src_ready_reg && bus.src_valid;

    always_comb begin
        state_next      = state_reg;
        next_addr_next  = next_addr_reg;
        word_count_next = word_count_reg;
        settle_next     = settle_reg;
        we_next         = 1'b0;
        wdata_next      = wdata_reg;
        waddr_next      = waddr_reg;
`ifdef INST_LOADER_CHECKSUM_EN
        sum_next        = sum_reg;
`endif

        case (state_reg)
            ST_IDLE, ST_RUN, ST_ERROR: begin
                if (start) begin
                    state_next      = ST_LOAD;
                    next_addr_next  = PC_INITIAL;
                    word_count_next = '0;
`ifdef INST_LOADER_CHECKSUM_EN
                    sum_next        = '0;
`endif
                end
            end

            ST_LOAD: begin
                if (beat) begin
                    // A beat beyond capacity is dropped, even if it is marked last.
                    if (word_count_reg == CNT_W'(MAX_WORDS)) begin
                        state_next = ST_ERROR;
                    end else begin
                        we_next         = 1'b1;
                        wdata_next      = bus.src_data;
                        waddr_next      = next_addr_reg;
                        next_addr_next  = next_addr_reg + 32'd4;
                        word_count_next = word_count_reg + 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
                        sum_next        = sum_with_beat;
`endif
                        if (bus.src_last) begin
                            if (checksum_ok) begin
                                state_next  = ST_SETTLE;
                                settle_next = ST_W'(SETTLE_CYCLES);
                            end else begin
                                state_next  = ST_ERROR;
                            end
                        end
                    end
                end
            end

            ST_SETTLE: begin
                if (settle_reg == '0) begin
                    state_next = ST_RUN;
                end else begin
                    settle_next = settle_reg - 1'b1;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Status outputs are registered copies of the next-state decode so they
    // change on the same edge as the state itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            next_addr_reg  <= PC_INITIAL;
            word_count_reg <= '0;
            settle_reg     <= '0;
            we_reg         <= 1'b0;
            wdata_reg      <= '0;
            waddr_reg      <= PC_INITIAL;
            cpu_reset_reg  <= 1'b1;
            debug_reg      <= 1'b1;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
            src_ready_reg  <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
            sum_reg        <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            next_addr_reg  <= next_addr_next;
            word_count_reg <= word_count_next;
            settle_reg     <= settle_next;
            we_reg         <= we_next;
            wdata_reg      <= wdata_next;
            waddr_reg      <= waddr_next;
            cpu_reset_reg  <= (state_next != ST_RUN);
            debug_reg      <= (state_next != ST_RUN);
            done_reg       <= (state_next == ST_RUN);
            error_reg      <= (state_next == ST_ERROR);
            src_ready_reg  <= (state_next == ST_LOAD);
`ifdef INST_LOADER_CHECKSUM_EN
            sum_reg        <= sum_next;
`endif
        end
    end

    assign bus.src_ready              = src_ready_reg;
    assign bus.inst_ram_write_enable  = we_reg;
    assign bus.inst_ram_write_data    = wdata_reg;
    assign bus.inst_ram_write_address = waddr_reg;
    assign cpu_reset                  = cpu_reset_reg;
    assign debug                      = debug_reg;
    assign done                       = done_reg;
    assign error                      = error_reg;
    assign word_count                 = word_count_reg;

endmodule

// File: doc/inst_ram_loader.md
# inst_ram_loader

Boot-time sequencer that owns the CPU's instruction-RAM write port and its reset/debug controls. It accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them to consecutive instruction-RAM addresses starting at the reset PC. While loading it holds the CPU in reset and debug mode, then waits a fixed settle period and releases the CPU to run. It sits between the program source (UART/ROM streamer or bench) and the `CPU` top-level ports `debug`, `reset`, and `inst_ram_write_*`.

## Interface
- `PC_INITIAL`, 32'hbfc00000, address of the first loaded word; also the CPU reset PC.
- `MAX_WORDS`, 1024, maximum number of words in one load.
- `SETTLE_CYCLES`, 8, number of cycles the CPU is held in reset after the last write (≥1).
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high loader reset.
- `start`  in  1  one-cycle pulse that begins a load; honoured in IDLE, RUN and ERROR.
- `src_valid`  in  1  source word valid.
- `src_data`  in  32  source instruction word.
- `src_last`  in  1  marks the final word of the program; qualified by `src_valid`.
- `src_ready`  out  1  loader accepts a word.
- `expected_checksum`  in  32  expected program sum; used only with checksum support compiled in.
- `inst_ram_write_enable`  out  1  instruction-RAM write strobe.
- `inst_ram_write_data`  out  32  word to write.
- `inst_ram_write_address`  out  32  byte address to write.
- `cpu_reset`  out  1  drives CPU `reset`; high holds the CPU in reset.
- `debug`  out  1  drives CPU `debug`.
- `done`  out  1  the CPU is running the loaded program.
- `error`  out  1  the load was aborted.
- `word_count`  out  clog2(MAX_WORDS+1)  number of words accepted in the current or last load.

## Operation
- States: IDLE, LOAD, SETTLE, RUN, ERROR.
- IDLE: `cpu_reset`=1, `debug`=1, `src_ready`=0. On `start` the loader clears `word_count` and the running sum, sets the next address to `PC_INITIAL`, and moves to LOAD.
- LOAD: `src_ready`=1, `cpu_reset`=1, `debug`=1.
  - A beat is accepted when `src_valid`&&`src_ready`.
  - Each accepted word is written to the next address, which then increments by 4 (wraps modulo 2^32).
  - `word_count` increments by 1 per accepted word.
- Last beat: the last word is written. The loader then moves to SETTLE with a counter loaded to `SETTLE_CYCLES`. `src_ready` drops the cycle after the last beat.
- Overflow: a beat accepted while `word_count`==`MAX_WORDS` is not written and moves the loader to ERROR. This applies whether or not `src_last` is set.
- SETTLE: `cpu_reset`=1, `debug`=1, no writes. The counter decrements each cycle; at 0 the loader moves to RUN.
- RUN: `cpu_reset`=0, `debug`=0, `done`=1.
- ERROR: `cpu_reset`=1, `debug`=1, `error`=1, `done`=0.
- `start` in RUN or ERROR begins a reload: next cycle the loader is in LOAD with `cpu_reset`=1, `debug`=1, `done`=0, `error`=0. `start` in LOAD or SETTLE is ignored.
- Reset values of all outputs:
  - `inst_ram_write_enable`=0, `inst_ram_write_data`=0, `inst_ram_write_address`=`PC_INITIAL`.
  - `cpu_reset`=1, `debug`=1.
  - `done`=0, `error`=0, `word_count`=0, `src_ready`=0.
- Reset mid-operation returns the loader to IDLE next cycle. No partial write strobe is emitted after the reset edge. The CPU stays in reset.

## Timing
- Write latency: the beat is accepted at edge N; `inst_ram_write_enable`, `_data` and `_address` are registered and valid for exactly the cycle after edge N.
- Throughput is one word per cycle. Write enable is low on cycles without an accepted beat.
- After the last beat at edge N, `cpu_reset` falls and `done` rises at edge N+1+`SETTLE_CYCLES`.
- All outputs are registered. `src_ready` is a function of the registered state only.

## Configuration
- `INST_LOADER_CHECKSUM_EN` defined:
  - A 32-bit sum (mod 2^32) accumulates over all written words.
  - On the last beat, the sum including the last word is compared with `expected_checksum` sampled at that edge.
  - On mismatch the last word is still written, but the loader goes to ERROR instead of SETTLE.
- Undefined: no accumulator is built, `expected_checksum` is ignored, and the last beat always leads to SETTLE.

## Test plan
- Basic load: reset, `start`, then stream 0x200F0AF4, 0x20180008, 0x01F87820 (last) back-to-back.
  - Required writes: 0xbfc00000, 0xbfc00004 and 0xbfc00008, one per cycle.
  - With `SETTLE_CYCLES`=8, `done`=1 and `cpu_reset`=0 exactly 9 cycles after the last beat; `word_count`=3.
- Source gaps: the same 3 words with `src_valid` low for 2 cycles between beats.
  - Required: identical addresses and data; `inst_ram_write_enable` low during the gaps.
- Overflow: `MAX_WORDS`=4, stream 5 words with no `src_last`.
  - Required: 4 writes to 0xbfc00000–0xbfc0000c, no fifth write, `error`=1, `cpu_reset`=1, `word_count`=4.
- Checksum (macro on): words 1, 2, 3 with `expected_checksum`=7.
  - Required: 3 writes, then ERROR.
  - Repeat with `expected_checksum`=6: required `done`=1.
  - With the macro off, either value reaches `done`.
- Reset mid-load: assert `reset` after 2 of 3 words.
  - Required: next cycle IDLE, no write strobe, `cpu_reset`=1, `word_count`=0.
- Reload from RUN: `start` in RUN.
  - Required: next cycle `cpu_reset`=1, `debug`=1, `done`=0; the new stream is written starting again at 0xbfc00000.
